// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between
// the CPU control path and an external loader/debug port.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ext_ack_q, ext_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              grant_ext;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_ack_d    = 1'b0;
    ext_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ext_rdata_d  = ext_rdata_q;
    // On a tie the side that did not win last time goes first.
    grant_ext    = ext_req & (~cpu_req | ~last_grant_q);

    case (state_q)
      IDLE: begin
        if (cpu_req || ext_req) begin
          owner_d      = grant_ext;
          last_grant_d = grant_ext;
          mem_we_d     = grant_ext ? ext_we    : cpu_we;
          mem_addr_d   = grant_ext ? ext_addr  : cpu_addr;
          mem_wdata_d  = grant_ext ? ext_wdata : cpu_wdata;
          mem_en_d     = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = CNT_INIT;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (owner_q) ext_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          cpu_ack_d = ~owner_q;
          ext_ack_d = owner_q;
          mem_en_d  = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      ext_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      ext_ack_q    <= ext_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ext_ack   = ext_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single-requester accesses plus
// hand-written sequences for arbitration, address hold, abort and starvation.
module tb_mem_port_arbiter;
  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0]  cpu_addr, ext_addr;
  logic [15:0] cpu_wdata, ext_wdata;
  logic [15:0] cpu_rdata, ext_rdata;
  logic        cpu_ack, ext_ack, cpu_stall;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        busy, owner;

  int total = 0;
  int bad   = 0;

  logic [15:0] tbmem [0:255];

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory model: contents reloaded on reset, combinational read.
  always @(posedge clk) begin
    if (reset) begin
      tbmem[8'h05] <= 16'h0505;
      tbmem[8'h10] <= 16'hBEEF;
      tbmem[8'h20] <= 16'h0000;
      tbmem[8'h30] <= 16'h5A5A;
      tbmem[8'h99] <= 16'hFFFF;
    end else if (mem_en && mem_we) begin
      tbmem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = tbmem[mem_addr];

  typedef struct {
    logic        ext;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_c;
    logic [15:0] exp_e;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    ext_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge while IDLE; returns at a negedge in the next IDLE cycle.
  task automatic do_access(input logic ext, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata);
    if (ext) begin
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    #1;
    if (!ext) chk("stall_c0", {31'd0, cpu_stall}, 32'd1);
    chk("busy_c0", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= WC; k++) begin
      @(negedge clk);
      chk("acc_mem_en", {31'd0, mem_en}, 32'd1);
      chk("acc_mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("acc_mem_addr", {24'd0, mem_addr}, {24'd0, addr});
      if (we) chk("acc_mem_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
      chk("acc_owner", {31'd0, owner}, {31'd0, ext});
      chk("acc_ack", {30'd0, cpu_ack, ext_ack}, 32'd0);
      if (!ext) chk("acc_stall", {31'd0, cpu_stall}, 32'd1);
    end
    @(negedge clk);
    chk("done_acks", {30'd0, cpu_ack, ext_ack}, ext ? 32'd1 : 32'd2);
    chk("done_mem_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd1);
    if (!ext) chk("done_stall", {31'd0, cpu_stall}, 32'd0);
    if (ext) ext_req = 1'b0; else cpu_req = 1'b0;
    @(negedge clk);
    chk("idle_acks", {30'd0, cpu_ack, ext_ack}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] order;
    int         grants, cyc;
    logic       rr_cpu, rr_ext, ack_seen;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h1234, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 8'h30, 16'h7777, 16'hBEEF, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'h7777, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h7777, 16'hBEEF};
    vecs[6] = '{1'b0, 1'b0, 8'h99, 16'h0000, 16'hFFFF, 16'hBEEF};

    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_we = 0; ext_addr = 0; ext_wdata = 0;
    reset = 1'b1; cpu_req = 0; ext_req = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem", {14'd0, mem_en, mem_we, mem_addr, 8'd0}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_ctrl", {28'd0, cpu_ack, ext_ack, owner, busy}, 32'd0);
    chk("rst_rdata", {cpu_rdata, ext_rdata}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].ext, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk("vec_cpu_rdata", {16'd0, cpu_rdata}, {16'd0, vecs[i].exp_c});
      chk("vec_ext_rdata", {16'd0, ext_rdata}, {16'd0, vecs[i].exp_e});
    end

    // Fairness with both requesters re-requesting after every ack.
    do_reset();
    order = 4'b1010;
    grants = 0; cyc = 0; rr_cpu = 0; rr_ext = 0;
    cpu_we = 0; cpu_addr = 8'h10; ext_we = 0; ext_addr = 8'h30;
    cpu_req = 1; ext_req = 1;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (rr_cpu) begin cpu_req = 1; rr_cpu = 0; end
      if (rr_ext) begin ext_req = 1; rr_ext = 0; end
      if (cpu_ack || ext_ack) begin
        chk("fair_overlap", {31'd0, cpu_ack & ext_ack}, 32'd0);
        chk("fair_order", {31'd0, ext_ack}, {31'd0, order[grants]});
        chk("fair_owner", {31'd0, owner}, {31'd0, order[grants]});
        if (cpu_ack) begin cpu_req = 0; rr_cpu = 1; end
        if (ext_ack) begin ext_req = 0; rr_ext = 1; end
        grants++;
      end
    end
    chk("fair_grants", grants, 4);
    cpu_req = 0; ext_req = 0;
    repeat (3) @(negedge clk);

    // Address change after grant must not reach the memory.
    cpu_we = 0; cpu_addr = 8'h05; cpu_req = 1;
    @(negedge clk);
    cpu_addr = 8'h06;
    #1;
    chk("hold_addr_c1", {24'd0, mem_addr}, 32'h05);
    @(negedge clk);
    chk("hold_addr_c2", {24'd0, mem_addr}, 32'h05);
    @(negedge clk);
    chk("hold_ack", {31'd0, cpu_ack}, 32'd1);
    cpu_req = 0;
    @(negedge clk);
    chk("hold_rdata", {16'd0, cpu_rdata}, 32'h0505);

    // Reset in the first ACCESS cycle aborts the access.
    ext_we = 1; ext_addr = 8'h40; ext_wdata = 16'hAAAA; ext_req = 1;
    @(negedge clk);
    chk("abort_c1_en", {31'd0, mem_en}, 32'd1);
    reset = 1;
    @(negedge clk);
    reset = 0; ext_req = 0;
    chk("abort_en", {30'd0, mem_en, mem_we}, 32'd0);
    chk("abort_busy", {29'd0, busy, cpu_ack, ext_ack}, 32'd0);
    ack_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack || ext_ack) ack_seen = 1;
    end
    chk("abort_no_ack", {31'd0, ack_seen}, 32'd0);
    do_access(1'b1, 1'b0, 8'h30, 16'h0000);
    chk("abort_reissue", {16'd0, ext_rdata}, 32'h5A5A);

    // CPU back-to-back with ext_req held: EXT must get the second slot.
    do_reset();
    cpu_we = 0; cpu_addr = 8'h10; ext_we = 0; ext_addr = 8'h99;
    cpu_req = 1; ext_req = 1;
    repeat (WC + 1) @(negedge clk);
    chk("starve_ack1", {30'd0, cpu_ack, ext_ack}, 32'd2);
    cpu_req = 0;
    @(negedge clk);
    cpu_addr = 8'h30; cpu_req = 1;
    @(negedge clk);
    chk("starve_owner_ext", {30'd0, mem_en, owner}, 32'd3);
    chk("starve_addr_ext", {24'd0, mem_addr}, 32'h99);
    repeat (WC) @(negedge clk);
    chk("starve_ack_ext", {30'd0, cpu_ack, ext_ack}, 32'd1);
    chk("starve_ext_rdata", {16'd0, ext_rdata}, 32'hFFFF);
    ext_req = 0;
    repeat (2) @(negedge clk);
    chk("starve_owner_cpu", {30'd0, mem_en, owner}, 32'd2);
    chk("starve_addr_cpu", {24'd0, mem_addr}, 32'h30);
    repeat (WC) @(negedge clk);
    chk("starve_ack_cpu", {30'd0, cpu_ack, ext_ack}, 32'd2);
    chk("starve_cpu_rdata", {16'd0, cpu_rdata}, 32'h5A5A);
    cpu_req = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters:
  - the multicycle CPU control path (fetch and lw/sw accesses);
  - an external port (program loader / debug).
- Sequences every access through a fixed-latency memory: request latching, wait-state counting, read-data capture and a one-cycle acknowledge.
- Holds the CPU FSM through `cpu_stall` while the CPU's access is pending.
- Round-robin tie-break, so neither requester starves.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory data width
- WAIT_CYCLES, 2, cycles the memory needs per access (legal range 1..15)

Ports:
- clk  in  1  single system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU access address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data for the CPU
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ext_req  in  1  external access request; held high until ext_ack
- ext_we  in  1  1 = write, 0 = read
- ext_addr  in  ADDR_W  external access address
- ext_wdata  in  DATA_W  external write data
- ext_rdata  out  DATA_W  registered read data for the external port
- ext_ack  out  1  one-cycle completion pulse to the external port
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle
- busy  out  1  high in ACCESS and DONE
- owner  out  1  current grant: 0 = CPU, 1 = external; meaningful only while busy

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; counter = 0; last_grant = 1 (EXT), so the CPU wins the first tie.
  - mem_en, mem_we, mem_addr, mem_wdata, cpu_ack, ext_ack, owner, busy = 0.
  - cpu_rdata, ext_rdata = 0.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the requester opposite to last_grant.
  - On grant:
    - latch we/addr/wdata of the winner;
    - set owner and last_grant to the winner;
    - counter = WAIT_CYCLES-1;
    - next state = ACCESS.
- ACCESS:
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the latched values, stable for all WAIT_CYCLES cycles.
  - Counter decrements each cycle.
  - When counter = 0:
    - if read, capture mem_rdata into the owner's rdata register;
    - next state = DONE.
- DONE:
  - mem_en = mem_we = 0.
  - Owner's ack = 1 for exactly this cycle.
  - Next state = IDLE.
- Latency:
  - req sampled in cycle 0;
  - mem_en high in cycles 1..WAIT_CYCLES;
  - ack in cycle WAIT_CYCLES+1;
  - earliest next grant is cycle WAIT_CYCLES+2.
- Requester protocol:
  - drop req at the clock edge that samples ack high, so req is low in the following IDLE cycle;
  - req still high in IDLE is treated as a new request.
- Requests are ignored while busy. Changes on requester address/data after grant have no effect.
- A write never updates any rdata register. Each rdata register holds its value until that requester's next read completes.
- Only the owner's ack ever pulses. cpu_ack and ext_ack are never high together.
- Reset during ACCESS or DONE:
  - access aborted, no ack issued, all outputs to reset values;
  - requester must reissue.
  - Memory write content is undefined if the abort occurs during a write.
- Fairness: with both reqs continuously asserted, grants alternate CPU, EXT, CPU, ...

Test Plan:
1. Reset, WAIT_CYCLES=2, CPU read addr 0x10, memory returns 0xBEEF -> mem_en=1, mem_we=0 in cycles 1-2; cpu_ack=1 in cycle 3 only; cpu_rdata=0xBEEF; cpu_stall=1 in cycles 0-2.
2. cpu_req and ext_req asserted together right after reset, both re-requesting after their acks -> grant order CPU, EXT, CPU, EXT; owner matches; acks never overlap.
3. EXT write addr 0x20 data 0x1234 -> mem_we=1 with mem_addr=0x20, mem_wdata=0x1234 for exactly 2 cycles; ext_ack pulse; ext_rdata and cpu_rdata unchanged.
4. CPU read addr 0x05 granted, then cpu_addr changed to 0x06 in cycle 1 -> mem_addr stays 0x05 for the whole access.
5. Reset asserted in cycle 1 of ACCESS -> next cycle mem_en=0, busy=0, no ack ever issued; a reissued request completes normally.
6. CPU back-to-back reads with ext_req held high -> the EXT access is granted immediately after the first CPU access completes (no starvation).
